// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard inputs and stage-register controls shared by pipeline and sequencer
// HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        md_busy;
  logic        mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, ex_md_start, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           md_busy, mem_err
`ifdef HAZARD_PERF_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           ex_branch_taken, ex_md_start, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           md_busy, mem_err
`ifdef HAZARD_PERF_EN
    , output stall_cycles, flush_events
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - five-stage pipeline enable/flush sequencer for load-use, branch, mul/div and memory waits
// Optional HAZARD_PERF_EN adds stall_cycles/flush_events counters.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 2);
  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       mem_err_q;
  logic       mem_err_nxt;

  logic       mem_stall;
  logic       load_use;
  logic       md_start;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       md_busy;

  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                     ((hz.ex_rd == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));
  assign md_start  = (state == RUN) & hz.ex_md_start & ~mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= 4'd0;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      md_cnt    <= md_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_q <= mem_err_nxt;
    end
  end

  // A memory stall freezes the whole sequencer, including the mul/div countdown.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (!mem_stall) begin
      case (state)
        RUN: begin
          if (hz.ex_md_start) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MD_RELOAD;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 4'd0) begin
            md_cnt_nxt = md_cnt - 4'd1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    if (mem_stall) begin
      wait_cnt_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    end else begin
      wait_cnt_nxt = 8'd0;
    end
    mem_err_nxt = mem_err_q | (mem_stall & (wait_cnt_nxt >= TIMEOUT));
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    md_busy     = (state == MD_BUSY) | md_start;

    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      md_busy  = 1'b0;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (state == MD_BUSY) begin
      if (md_cnt != 4'd0) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b1;
      end
    end else if (hz.ex_md_start) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      // The squashed ID instruction makes any load-use stall irrelevant.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_flush = memwb_flush;
  assign hz.md_busy     = md_busy;
  assign hz.mem_err     = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, ~pc_en};
      flush_events <= flush_events + {31'd0, ifid_flush};
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl against an occupancy-based reference model
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 4;
  localparam int TMO    = 5;

  typedef logic [10:0] obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if hz ();

  hazard_stall_ctrl #(
    .MD_LATENCY  (MD_LAT),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  int    md_rem    = 0;
  int    stall_run = 0;
  bit    err       = 1'b0;

  function automatic obs_t observe();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush,
            hz.md_busy, hz.mem_err};
  endfunction

  // md_rem = EX cycles still owed to the current mul/div, counting the present one.
  task automatic step(input string tag);
    bit pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, f_memwb, busy;
    bit stall, lu, freeze;
    obs_t e;
    stall = hz.mem_req && !hz.mem_ready;
    lu    = hz.ex_mem_read && hz.ex_rd != 0 &&
            (hz.ex_rd == hz.id_rs || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
    if (rst) begin
      e         = '0;
      md_rem    = 0;
      stall_run = 0;
      err       = 1'b0;
    end else begin
      {pc, ifid, idex, exmem, memwb} = 5'b11111;
      {f_ifid, f_idex, f_exmem, f_memwb} = 4'b0000;
      freeze = 1'b0;
      busy   = (md_rem > 0) || (hz.ex_md_start && !stall);
      if (stall) begin
        {pc, ifid, idex, exmem} = 4'b0000;
        f_memwb = 1'b1;
      end else if (md_rem == 1) begin
        md_rem = 0;
      end else if (md_rem > 1) begin
        freeze = 1'b1;
        md_rem = md_rem - 1;
      end else if (hz.ex_md_start) begin
        freeze = 1'b1;
        md_rem = MD_LAT - 1;
      end else if (hz.ex_branch_taken) begin
        f_ifid = 1'b1;
        f_idex = 1'b1;
      end else if (lu) begin
        pc     = 1'b0;
        ifid   = 1'b0;
        f_idex = 1'b1;
      end
      if (freeze) begin
        {pc, ifid, idex, exmem} = 4'b0000;
        f_exmem = 1'b1;
      end
      e = {pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, f_memwb, busy, err};
      if (stall) begin
        stall_run = (stall_run < 255) ? stall_run + 1 : 255;
        if (stall_run >= TMO) err = 1'b1;
      end else begin
        stall_run = 0;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0;
    hz.ex_branch_taken = 1'b0; hz.ex_md_start = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t  e;
        obs_t  a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = observe();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s at %0t: actual %b required %b (pc ifid idex exmem memwb | fl_ifid fl_idex fl_exmem fl_memwb | busy err)",
                   t, $time, a, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset_hold");
    rst = 1'b0;
    step("idle_run");

    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8;
    step("load_use_stall");
    hz.ex_mem_read = 1'b0;
    step("load_use_release");
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs = 5'd0;
    step("load_use_r0");
    hz.ex_rd = 5'd9; hz.id_rs = 5'd1; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1;
    step("load_use_rt");
    hz.id_uses_rt = 1'b0;
    step("load_use_rt_unused");

    hz.ex_rd = 5'd8; hz.id_rs = 5'd8; hz.ex_branch_taken = 1'b1;
    step("branch_beats_load_use");
    idle();

    hz.ex_md_start = 1'b1;
    for (int i = 0; i < MD_LAT; i++) step("md_occupancy");
    hz.ex_md_start = 1'b0;
    step("md_back_to_run");

    hz.ex_md_start = 1'b1;
    step("md_wait_start");
    hz.ex_md_start = 1'b0;
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("md_mem_wait");
    hz.mem_ready = 1'b1;
    for (int i = 0; i < MD_LAT; i++) step("md_after_wait");
    idle();

    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < TMO + 1; i++) step("mem_timeout");
    hz.mem_ready = 1'b1;
    step("mem_err_sticky");
    step("mem_err_sticky2");
    rst = 1'b1;
    step("mem_err_reset");
    rst = 1'b0;
    step("mem_err_cleared");

    hz.ex_md_start = 1'b1;
    step("md_before_reset");
    hz.ex_md_start = 1'b0;
    step("md_busy_before_reset");
    rst = 1'b1;
    step("async_reset_mid_md");
    rst = 1'b0;
    step("run_after_reset");

    for (int n = 0; n < 1500; n++) begin
      rst                = ($urandom_range(0, 99) < 2);
      hz.id_rs           = 5'($urandom_range(0, 3));
      hz.id_rt           = 5'($urandom_range(0, 3));
      hz.id_uses_rt      = 1'($urandom_range(0, 1));
      hz.ex_mem_read     = 1'($urandom_range(0, 1));
      hz.ex_rd           = 5'($urandom_range(0, 3));
      hz.ex_branch_taken = ($urandom_range(0, 99) < 20);
      hz.ex_md_start     = ($urandom_range(0, 99) < 15);
      hz.mem_req         = 1'($urandom_range(0, 1));
      hz.mem_ready       = ($urandom_range(0, 99) < 60);
      step("random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
